// File: rtl/bsg_tag_pkg.sv
// Shared types for the bsg_tag transmit path.
//   BSG_SAFE_CLOG2            : clog2 that never returns 0
//   declare_BSG_TAG_TX_REQ_S  : request struct sized by node-id and length widths
//   bsg_tag_tx_state_e        : serializer FSM states
//   bsg_tag_max               : elaboration-time max helper

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

`define declare_BSG_TAG_TX_REQ_S(lg_els, lg_width) \
  typedef struct packed { \
    logic                       reset_seq; \
    logic [(lg_els)-1:0]        node_id; \
    logic                       data_not_reset; \
    logic [(lg_width)-1:0]      len; \
    logic [(2**(lg_width))-2:0] payload; \
  } bsg_tag_tx_req_s

package bsg_tag_pkg;

  typedef enum logic [2:0] {
    e_tx_idle,
    e_tx_start,
    e_tx_len,
    e_tx_dnr,
    e_tx_node,
    e_tx_payload,
    e_tx_gap,
    e_tx_resetseq
  } bsg_tag_tx_state_e;

  function automatic int bsg_tag_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_tag_serializer_shift.sv
// Loadable LSB-first shift register with a down-counter of remaining bits.
//   clk, reset_n : clock, async active-low reset
//   load         : capture load_data / load_count (wins over shift)
//   load_data    : vector to serialize, bit 0 goes out first
//   load_count   : number of bits that will be shifted out
//   shift        : advance one bit
//   serial       : current output bit (bit 0 of the register)
//   last         : the bit on serial is the final counted bit

module bsg_tag_serializer_shift
  import bsg_tag_pkg::*;
#(
  parameter int width_p     = 29,
  parameter int cnt_width_p = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [width_p-1:0]     load_data,
  input  logic [cnt_width_p-1:0] load_count,
  input  logic                   shift,
  output logic                   serial,
  output logic                   last
);

  logic [width_p-1:0]     data_r;
  logic [cnt_width_p-1:0] count_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r  <= '0;
      count_r <= '0;
    end else if (load) begin
      data_r  <= load_data;
      count_r <= load_count;
    end else if (shift) begin
      data_r  <= {1'b0, data_r[width_p-1:1]};
      count_r <= count_r - cnt_width_p'(1);
    end
  end

  assign serial = data_r[0];
  assign last   = (count_r == cnt_width_p'(1));

endmodule

// File: rtl/bsg_tag_serializer.sv
// Transmit end of the bsg_tag serial protocol: one packet or master-reset
// run per handshake, shifted out one bit per clk_i.
//   clk_i, reset_n_i  : clock, async active-low reset
//   v_i / ready_and_o : request handshake (ready only in IDLE, registered)
//   reset_seq_i       : send master-reset run instead of a packet
//   node_id_i, data_not_reset_i, len_i, payload_i : packet fields
//   tag_data_o, tag_en_o : serial tag pins
//   busy_o            : FSM not in IDLE
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | en=0, ready; waits for a request
// START     | start bit (1)
// LEN       | lg_width_p length bits, LSB first
// DNR       | data_not_reset bit
// NODE      | lg_els_lp node-id bits, LSB first
// PAYLOAD   | len payload bits, LSB first (skipped when len=0)
// GAP       | gap_p zero bits with en=1 (skipped when gap_p=0)
// RESETSEQ  | reset_ones_p ones for the master reset

module bsg_tag_serializer
  import bsg_tag_pkg::*;
#(
  parameter  int els_p                = 136,
  parameter  int lg_width_p           = 4,
  parameter  int reset_ones_p         = 64,
  parameter  int gap_p                = 4,
  localparam int lg_els_lp            = `BSG_SAFE_CLOG2(els_p),
  localparam int max_payload_width_lp = (2**lg_width_p) - 1
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            v_i,
  output logic                            ready_and_o,
  input  logic                            reset_seq_i,
  input  logic [lg_els_lp-1:0]            node_id_i,
  input  logic                            data_not_reset_i,
  input  logic [lg_width_p-1:0]           len_i,
  input  logic [max_payload_width_lp-1:0] payload_i,
  output logic                            tag_data_o,
  output logic                            tag_en_o,
  output logic                            busy_o
);

  localparam int vec_width_lp = max_payload_width_lp + lg_els_lp + lg_width_p + 2;
  localparam int sh_cnt_w_lp  = `BSG_SAFE_CLOG2(vec_width_lp + 1);
  localparam int timer_max_lp = bsg_tag_max(bsg_tag_max(reset_ones_p, gap_p),
                                            bsg_tag_max(lg_els_lp, lg_width_p));
  localparam int timer_w_lp   = `BSG_SAFE_CLOG2(timer_max_lp + 1);

  // Where the body of a packet or reset run goes next, and the gap timer load.
  localparam bsg_tag_tx_state_e after_body_lp = (gap_p == 0) ? e_tx_idle : e_tx_gap;
  localparam logic [timer_w_lp-1:0] gap_load_lp = timer_w_lp'((gap_p == 0) ? 0 : gap_p - 1);

  `declare_BSG_TAG_TX_REQ_S(lg_els_lp, lg_width_p);

  bsg_tag_tx_req_s req;
  assign req = '{reset_seq:      reset_seq_i,
                 node_id:        node_id_i,
                 data_not_reset: data_not_reset_i,
                 len:            len_i,
                 payload:        payload_i};

  bsg_tag_tx_state_e       state_r, state_n;
  logic [timer_w_lp-1:0]   timer_r, timer_n;
  logic                    ready_r;
  logic                    sh_load, sh_shift, sh_serial, sh_last;
  logic [vec_width_lp-1:0] sh_vec;
  logic [sh_cnt_w_lp-1:0]  sh_count;

  // Whole packet goes through one shifter; its count covers start..payload,
  // so PAYLOAD ends (or is skipped) exactly when the shifter reports last.
  assign sh_vec   = {req.payload, req.node_id, req.data_not_reset, req.len, 1'b1};
  assign sh_count = sh_cnt_w_lp'(2 + lg_width_p + lg_els_lp) + sh_cnt_w_lp'(req.len);

  bsg_tag_serializer_shift #(
    .width_p     (vec_width_lp),
    .cnt_width_p (sh_cnt_w_lp)
  ) shifter (
    .clk        (clk_i),
    .reset_n    (reset_n_i),
    .load       (sh_load),
    .load_data  (sh_vec),
    .load_count (sh_count),
    .shift      (sh_shift),
    .serial     (sh_serial),
    .last       (sh_last)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_tx_idle;
      timer_r <= '0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_n;
      timer_r <= timer_n;
      ready_r <= (state_n == e_tx_idle);
    end
  end

  always_comb begin
    state_n  = state_r;
    timer_n  = timer_r;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    case (state_r)
      e_tx_idle: begin
        if (v_i && ready_r) begin
          if (req.reset_seq) begin
            state_n = e_tx_resetseq;
            timer_n = timer_w_lp'(reset_ones_p - 1);
          end else begin
            state_n = e_tx_start;
            sh_load = 1'b1;
          end
        end
      end
      e_tx_start: begin
        sh_shift = 1'b1;
        state_n  = e_tx_len;
        timer_n  = timer_w_lp'(lg_width_p - 1);
      end
      e_tx_len: begin
        sh_shift = 1'b1;
        if (timer_r == '0) state_n = e_tx_dnr;
        else               timer_n = timer_r - timer_w_lp'(1);
      end
      e_tx_dnr: begin
        sh_shift = 1'b1;
        state_n  = e_tx_node;
        timer_n  = timer_w_lp'(lg_els_lp - 1);
      end
      e_tx_node: begin
        sh_shift = 1'b1;
        if (timer_r != '0) begin
          timer_n = timer_r - timer_w_lp'(1);
        end else if (sh_last) begin
          state_n = after_body_lp;
          timer_n = gap_load_lp;
        end else begin
          state_n = e_tx_payload;
        end
      end
      e_tx_payload: begin
        sh_shift = 1'b1;
        if (sh_last) begin
          state_n = after_body_lp;
          timer_n = gap_load_lp;
        end
      end
      e_tx_resetseq: begin
        if (timer_r == '0) begin
          state_n = after_body_lp;
          timer_n = gap_load_lp;
        end else begin
          timer_n = timer_r - timer_w_lp'(1);
        end
      end
      e_tx_gap: begin
        if (timer_r == '0) state_n = e_tx_idle;
        else               timer_n = timer_r - timer_w_lp'(1);
      end
      default: state_n = e_tx_idle;
    endcase
  end

  always_comb begin
    case (state_r)
      e_tx_start, e_tx_len, e_tx_dnr, e_tx_node, e_tx_payload: tag_data_o = sh_serial;
      e_tx_resetseq: tag_data_o = 1'b1;
      default:       tag_data_o = 1'b0;
    endcase
  end

  assign tag_en_o    = (state_r != e_tx_idle);
  assign busy_o      = (state_r != e_tx_idle);
  assign ready_and_o = ready_r;

`ifndef SYNTHESIS
  logic v_wait_r;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_wait_r <= 1'b0;
    end else begin
      v_wait_r <= v_i & ~ready_and_o;
      assert (reset_ones_p > vec_width_lp)
        else $error("bsg_tag_serializer: reset_ones_p must exceed the longest packet");
      assert (!(v_wait_r && !v_i))
        else $error("bsg_tag_serializer: v_i dropped before ready_and_o");
    end
  end
`endif

endmodule
